// File: rtl/fetch_stage_pkg.sv
// Shared pipeline bundle types and constants.
// Used by the fetch stage and its response buffer.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int          FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } FetchInfo;

  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;

  typedef struct packed {
    logic       stall_req;
    logic [3:0] flush_req;
  } PipeRequest;

  function automatic logic [31:0] align_pc(
    input logic [31:0] pc
  );
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer with push, pop and clear.
// Used both for issued pcs and for fetched {pc, inst} pairs.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop && (r_cnt != 2'd0);
  // A full buffer still accepts a push when it pops in the same cycle.
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_clear) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-limited imem requests, redirect
// squashing and a registered {pc, inst} output for decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  PipeControl  pipe,
  output PipeRequest  req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output FetchInfo    fetch_info,
  output logic        error
);

  localparam FetchInfo BUBBLE = '{pc: 32'h0, inst: NOP_INST};

  logic [31:0] r_pc;
  logic [1:0]  r_out;
  logic [1:0]  r_drop;
  logic        r_err;
  FetchInfo    r_fi;

  FetchInfo    w_fi_d;
  FetchInfo    w_fifo_head;
  FetchInfo    w_resp_pair;
  logic [31:0] w_pcq_head;
  logic [1:0]  w_pcq_cnt;
  logic [1:0]  w_fifo_cnt;
  logic [2:0]  w_credit;
  logic        w_acc;
  logic        w_resp;
  logic        w_keep;
  logic        w_take;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  logic        w_fifo_empty;

  assign req = '{stall_req: 1'b0, flush_req: 4'b0000};

  assign w_credit = {1'b0, r_out} + {1'b0, w_fifo_cnt};
  assign imem_req_valid = rst_n && !redirect_valid &&
                          (w_credit < 3'd2);
  assign imem_addr = r_pc;
  assign w_acc = imem_req_valid && imem_req_ready;

  assign w_resp = imem_resp_valid && (w_pcq_cnt != 2'd0);
  assign w_keep = w_resp && !redirect_valid &&
                  (r_drop == 2'd0);
  assign w_take = !pipe.stall && !pipe.flush &&
                  !redirect_valid;
  assign w_fifo_empty = (w_fifo_cnt == 2'd0);
  // An empty buffer lets a fresh response go straight to decode.
  assign w_bypass = w_keep && w_take && w_fifo_empty;
  assign w_push = w_keep && !w_bypass;
  assign w_pop  = w_take && !w_fifo_empty;
  assign w_resp_pair = '{pc: w_pcq_head, inst: imem_resp_data};

  fetch_fifo #(.W(32)) u_pcq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_acc),
    .i_pop   (w_resp),
    .i_clear (1'b0),
    .i_data  (r_pc),
    .o_data  (w_pcq_head),
    .o_count (w_pcq_cnt)
  );

  fetch_fifo #(.W(64)) u_rfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .i_data  (w_resp_pair),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_cnt)
  );

  always_comb begin
    w_fi_d = BUBBLE;
    if (pipe.stall) begin
      w_fi_d = r_fi;
    end else if (pipe.flush || redirect_valid) begin
      w_fi_d = BUBBLE;
    end else if (!w_fifo_empty) begin
      w_fi_d = w_fifo_head;
    end else if (w_bypass) begin
      w_fi_d = w_resp_pair;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_out  <= 2'd0;
      r_drop <= 2'd0;
      r_err  <= 1'b0;
      r_fi   <= BUBBLE;
    end else begin
      r_fi  <= w_fi_d;
      r_out <= r_out + {1'b0, w_acc} - {1'b0, w_resp};
      if (redirect_valid) begin
        r_pc   <= align_pc(redirect_pc);
        r_drop <= r_out - {1'b0, w_resp};
      end else begin
        if (w_acc) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_resp && (r_drop != 2'd0)) begin
          r_drop <= r_drop - 2'd1;
        end
      end
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign fetch_info = r_fi;
  assign error      = r_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle-latency
// in-order instruction memory model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  PipeControl  pipe;
  PipeRequest  req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  FetchInfo    fetch_info;
  logic        error;

  int          n_chk;
  int          n_err;
  logic        resp_en;
  logic        tb_req_v;
  logic [31:0] tb_addr;
  logic [31:0] q[$];
  logic [63:0] held;

  localparam logic [63:0] BUB = {32'h0, 32'h0000_0013};

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pipe            (pipe),
    .req             (req),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fetch_info      (fetch_info),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] fi(input logic [31:0] a);
    return {a, a ^ 32'hDEAD_0000};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (resp_en && q.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = q[0] ^ 32'hDEAD_0000;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    @(negedge clk);
    tb_req_v = imem_req_valid;
    tb_addr  = imem_addr;
    @(posedge clk);
    if (imem_resp_valid) void'(q.pop_front());
    if (tb_req_v && imem_req_ready) q.push_back(tb_addr);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    pipe = '{stall: 1'b0, flush: 1'b0};
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    resp_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_fi", fetch_info, BUB);
    chk("rst_err", {63'h0, error}, 64'h0);
    chk("rst_rqv", {63'h0, imem_req_valid}, 64'h0);
    chk("req_out", {59'h0, req}, 64'h0);
    rst_n = 1'b1;

    // streaming, memory always ready
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) begin
        chk("addr0", {32'h0, tb_addr}, 64'h0);
        chk("rqv0", {63'h0, tb_req_v}, 64'h1);
        chk("warm", fetch_info, BUB);
      end else begin
        chk("seq", fetch_info, fi(32'(4 * (k - 2))));
      end
    end

    // stall for three cycles with responses pending
    held = fetch_info;
    pipe.stall = 1'b1;
    tick();
    chk("stl_h0", fetch_info, held);
    tick();
    chk("stl_h1", fetch_info, held);
    chk("stl_rq1", {63'h0, tb_req_v}, 64'h0);
    tick();
    chk("stl_h2", fetch_info, held);
    chk("stl_rq2", {63'h0, tb_req_v}, 64'h0);
    pipe.stall = 1'b0;
    tick();
    chk("stl_d0", fetch_info, fi(32'd24));
    tick();
    chk("stl_d1", fetch_info, fi(32'd28));
    tick();
    chk("stl_d2", fetch_info, fi(32'd32));

    // redirect with two requests outstanding
    resp_en = 1'b0;
    tick();
    chk("gap0", fetch_info, BUB);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    chk("rd_rqv", {63'h0, tb_req_v}, 64'h0);
    chk("rd_b0", fetch_info, BUB);
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    tick();
    chk("rd_b1", fetch_info, BUB);
    chk("rd_cred", {63'h0, tb_req_v}, 64'h0);
    tick();
    chk("rd_b2", fetch_info, BUB);
    chk("rd_addr", {32'h0, tb_addr}, 64'h100);
    tick();
    chk("rd_pc", fetch_info, fi(32'h100));

    // redirect coincident with a response
    resp_en = 1'b0;
    tick();
    resp_en = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    chk("co_b0", fetch_info, BUB);
    redirect_valid = 1'b0;
    tick();
    chk("co_b1", fetch_info, BUB);
    chk("co_addr", {32'h0, tb_addr}, 64'h200);
    tick();
    chk("co_pc", fetch_info, fi(32'h200));

    // misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();
    chk("mis_err", {63'h0, error}, 64'h1);
    chk("mis_b", fetch_info, BUB);
    redirect_valid = 1'b0;
    tick();
    chk("mis_addr", {32'h0, tb_addr}, 64'h100);
    tick();
    chk("mis_pc", fetch_info, fi(32'h100));

    // flush, then same-cycle push and pop
    pipe.flush = 1'b1;
    tick();
    chk("fl_b", fetch_info, BUB);
    chk("stky", {63'h0, error}, 64'h1);
    pipe.flush = 1'b0;
    tick();
    chk("fl_d0", fetch_info, fi(32'h104));
    tick();
    chk("fl_d1", fetch_info, fi(32'h108));
    tick();

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    imem_resp_valid = 1'b0;
    q.delete();
    #1;
    chk("ar_fi", fetch_info, BUB);
    chk("ar_err", {63'h0, error}, 64'h0);
    chk("ar_rqv", {63'h0, imem_req_valid}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_addr", {32'h0, tb_addr}, 64'h0);
    chk("ar_rq", {63'h0, tb_req_v}, 64'h1);
    tick();
    chk("ar_pc", fetch_info, fi(32'h0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
